// File: rtl/pma_pkg.sv
// Shared types and attribute-byte layout for the runtime PMA region table.
package pma_pkg;

    localparam int unsigned PMA_ATTR_W      = 3;
    localparam int unsigned PMA_CACHED_BIT  = 0;
    localparam int unsigned PMA_EXEC_BIT    = 1;
    localparam int unsigned PMA_NONIDEM_BIT = 2;
    localparam int unsigned PMA_LOCK_BIT    = 7;

    typedef struct packed {
        logic nonidem;
        logic exec;
        logic cached;
    } pma_attr_t;

    typedef enum logic [1:0] {
        PMA_BASE   = 2'd0,
        PMA_LENGTH = 2'd1,
        PMA_ATTR   = 2'd2
    } pma_field_e;

    // Software-visible attr byte: lock in bit 7, bits 6:3 always zero.
    function automatic logic [7:0] attr_to_byte(input logic lock, input pma_attr_t attr);
        logic [7:0] b;
        b               = '0;
        b[PMA_LOCK_BIT] = lock;
        b[2:0]          = attr;
        return b;
    endfunction

endpackage

// File: rtl/pma_region_table_if.sv
// Config port and per-port lookup channels of the PMA region table.
interface pma_region_table_if #(
    parameter int unsigned NrRules   = 8,
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 64
);
    localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic                          cfg_req_i;
    logic                          cfg_we_i;
    logic [IdxWidth-1:0]           cfg_idx_i;
    logic [1:0]                    cfg_field_i;
    logic [AddrWidth-1:0]          cfg_wdata_i;
    logic                          cfg_rvalid_o;
    logic [AddrWidth-1:0]          cfg_rdata_o;
    logic                          cfg_err_o;

    logic [NrPorts-1:0]            lkp_valid_i;
    logic [NrPorts*AddrWidth-1:0]  lkp_addr_i;
    logic [NrPorts-1:0]            lkp_valid_o;
    logic [NrPorts*3-1:0]          lkp_attr_o;
    logic [NrPorts-1:0]            lkp_hit_o;
    logic [NrPorts*IdxWidth-1:0]   lkp_idx_o;

    modport master (
        output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
        output lkp_valid_i, lkp_addr_i,
        input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        input  lkp_valid_o, lkp_attr_o, lkp_hit_o, lkp_idx_o
    );

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
        input  lkp_valid_i, lkp_addr_i,
        output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        output lkp_valid_o, lkp_attr_o, lkp_hit_o, lkp_idx_o
    );

endinterface

// File: rtl/pma_rule_match.sv
// Single-rule range comparator; end address kept one bit wider so regions can reach the top of memory.
module pma_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base,
    input  logic [AddrWidth-1:0] len,
    input  logic [AddrWidth-1:0] addr,
    output logic                 match_c
);

    logic [AddrWidth:0] end_addr;

    assign end_addr = {1'b0, base} + {1'b0, len};
    assign match_c  = (len != '0) && (addr >= base) && ({1'b0, addr} < end_addr);

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table: register-style config port plus NrPorts two-stage lookup pipelines.
module pma_region_table
    import pma_pkg::*;
#(
    parameter int unsigned                  NrRules       = 8,
    parameter int unsigned                  NrPorts       = 2,
    parameter int unsigned                  AddrWidth     = 64,
    parameter logic [NrRules*AddrWidth-1:0] RuleRstBase   = '0,
    parameter logic [NrRules*AddrWidth-1:0] RuleRstLength = '0,
    parameter logic [NrRules*8-1:0]         RuleRstAttr   = '0,
    parameter logic [2:0]                   DefaultAttr   = 3'b000
) (
    input logic               clk_i,
    input logic               rst_i,
    pma_region_table_if.slave bus
);

    localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    pma_attr_t            attr_q [NrRules];
    logic [NrRules-1:0]   lock_q;

    logic                 idx_ok_c;
    logic                 err_c;
    logic                 wr_en_c;
    logic [AddrWidth-1:0] rdata_c;
    pma_field_e           field_c;

    assign idx_ok_c = 32'(bus.cfg_idx_i) < NrRules;
    assign field_c  = pma_field_e'(bus.cfg_field_i);

    // Config decode: read mux, error classification and write enable.
    always_comb begin
        err_c   = 1'b0;
        wr_en_c = 1'b0;
        rdata_c = '0;
        if (bus.cfg_req_i) begin
            if (!idx_ok_c || bus.cfg_field_i == 2'd3) begin
                err_c = 1'b1;
            end else if (bus.cfg_we_i) begin
                err_c   = lock_q[bus.cfg_idx_i];
                wr_en_c = !lock_q[bus.cfg_idx_i];
            end else begin
                case (field_c)
                    PMA_BASE:   rdata_c = base_q[bus.cfg_idx_i];
                    PMA_LENGTH: rdata_c = len_q[bus.cfg_idx_i];
                    PMA_ATTR:   rdata_c = AddrWidth'(attr_to_byte(lock_q[bus.cfg_idx_i],
                                                                  attr_q[bus.cfg_idx_i]));
                    default:    rdata_c = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NrRules; r++) begin
                base_q[r] <= RuleRstBase[r*AddrWidth +: AddrWidth];
                len_q[r]  <= RuleRstLength[r*AddrWidth +: AddrWidth];
                attr_q[r] <= pma_attr_t'(RuleRstAttr[r*8 +: PMA_ATTR_W]);
                lock_q[r] <= RuleRstAttr[r*8 + PMA_LOCK_BIT];
            end
        end else if (wr_en_c) begin
            case (field_c)
                PMA_BASE:   base_q[bus.cfg_idx_i] <= bus.cfg_wdata_i;
                PMA_LENGTH: len_q[bus.cfg_idx_i]  <= bus.cfg_wdata_i;
                PMA_ATTR: begin
                    attr_q[bus.cfg_idx_i] <= pma_attr_t'(bus.cfg_wdata_i[PMA_ATTR_W-1:0]);
                    if (bus.cfg_wdata_i[PMA_LOCK_BIT]) lock_q[bus.cfg_idx_i] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.cfg_rvalid_o <= 1'b0;
            bus.cfg_rdata_o  <= '0;
            bus.cfg_err_o    <= 1'b0;
        end else begin
            bus.cfg_rvalid_o <= bus.cfg_req_i;
            bus.cfg_rdata_o  <= rdata_c;
            bus.cfg_err_o    <= err_c;
        end
    end

    logic [NrPorts-1:0][NrRules-1:0] match_c;
    logic [NrPorts-1:0][NrRules-1:0] match_q;
    logic [NrPorts-1:0]              vld1_q;
    pma_attr_t                       attr_s1_q [NrRules];

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        for (genvar r = 0; r < NrRules; r++) begin : g_rule
            pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
                .base    (base_q[r]),
                .len     (len_q[r]),
                .addr    (bus.lkp_addr_i[p*AddrWidth +: AddrWidth]),
                .match_c (match_c[p][r])
            );
        end
    end

    // Stage 1 snapshots the attrs with the match vectors so later writes cannot affect in-flight lookups.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld1_q  <= '0;
            match_q <= '0;
            for (int r = 0; r < NrRules; r++) attr_s1_q[r] <= '0;
        end else begin
            vld1_q  <= bus.lkp_valid_i;
            match_q <= match_c;
            for (int r = 0; r < NrRules; r++) attr_s1_q[r] <= attr_q[r];
        end
    end

    logic [NrPorts-1:0]  hit_c;
    logic [IdxWidth-1:0] idx_c  [NrPorts];
    pma_attr_t           pattr_c [NrPorts];

    // Lowest matching index wins, so scan from the top and let lower indices overwrite.
    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            hit_c[p]   = 1'b0;
            idx_c[p]   = '0;
            pattr_c[p] = pma_attr_t'(DefaultAttr);
            for (int r = NrRules - 1; r >= 0; r--) begin
                if (match_q[p][r]) begin
                    hit_c[p]   = 1'b1;
                    idx_c[p]   = IdxWidth'(r);
                    pattr_c[p] = attr_s1_q[r];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.lkp_valid_o <= '0;
            bus.lkp_hit_o   <= '0;
            bus.lkp_idx_o   <= '0;
            bus.lkp_attr_o  <= '0;
        end else begin
            bus.lkp_valid_o <= vld1_q;
            for (int p = 0; p < NrPorts; p++) begin
                bus.lkp_hit_o[p]                       <= vld1_q[p] & hit_c[p];
                bus.lkp_idx_o[p*IdxWidth +: IdxWidth]  <= vld1_q[p] ? idx_c[p] : '0;
                bus.lkp_attr_o[p*PMA_ATTR_W +: PMA_ATTR_W] <= vld1_q[p] ? pattr_c[p] : '0;
            end
        end
    end

endmodule

// File: tb/tb_pma_region_table.sv
// Randomized and directed bench for pma_region_table against a range-arithmetic reference model.
module tb_pma_region_table;

    localparam int unsigned NR   = 6;
    localparam int unsigned NP   = 2;
    localparam int unsigned AW   = 64;
    localparam logic [2:0]  DEF  = 3'b000;

    logic clk;
    logic rst;

    pma_region_table_if #(.NrRules(NR), .NrPorts(NP), .AddrWidth(AW)) bus ();

    pma_region_table #(
        .NrRules       (NR),
        .NrPorts       (NP),
        .AddrWidth     (AW),
        .RuleRstBase   ((NR*AW)'(64'h8000_0000)),
        .RuleRstLength ((NR*AW)'(64'h4000_0000)),
        .RuleRstAttr   ((NR*8)'(8'h03)),
        .DefaultAttr   (DEF)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [2:0]  m_attr [NR];
    bit          m_lock [NR];

    typedef struct {
        bit         v;
        bit         hit;
        logic [2:0] idx;
        logic [2:0] attr;
    } exp_t;

    exp_t prev [NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = (i == 0) ? 64'h8000_0000 : 64'h0;
            m_len[i]  = (i == 0) ? 64'h4000_0000 : 64'h0;
            m_attr[i] = (i == 0) ? 3'b011 : 3'b000;
            m_lock[i] = 1'b0;
        end
    endfunction

    // A region covers a exactly when a sits at or above base and its offset is below the length.
    function automatic exp_t ref_lookup(input logic [63:0] a);
        exp_t e;
        e.v = 1'b1; e.hit = 1'b0; e.idx = '0; e.attr = DEF;
        for (int i = 0; i < NR; i++) begin
            if (!e.hit && m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
                e.hit  = 1'b1;
                e.idx  = 3'(i);
                e.attr = m_attr[i];
            end
        end
        return e;
    endfunction

    task automatic cycle(input bit r, input bit req, input bit we, input int idx, input int field,
                         input logic [63:0] wdata, input logic [1:0] lv,
                         input logic [63:0] a0, input logic [63:0] a1);
        exp_t        cur [NP];
        logic [63:0] addrs [NP];
        bit          e_rv;
        bit          e_err;
        logic [63:0] e_rd;

        rst              = r;
        bus.cfg_req_i    = req;
        bus.cfg_we_i     = we;
        bus.cfg_idx_i    = 3'(idx);
        bus.cfg_field_i  = 2'(field);
        bus.cfg_wdata_i  = wdata;
        bus.lkp_valid_i  = lv;
        bus.lkp_addr_i   = {a1, a0};
        addrs[0] = a0;
        addrs[1] = a1;

        for (int p = 0; p < NP; p++) begin
            cur[p] = '{v: 1'b0, hit: 1'b0, idx: 3'b0, attr: 3'b0};
            if (lv[p] && !r) cur[p] = ref_lookup(addrs[p]);
        end

        e_rv = req && !r; e_err = 1'b0; e_rd = '0;
        if (r) begin
            model_reset();
        end else if (req) begin
            if (idx >= NR || field == 3) begin
                e_err = 1'b1;
            end else if (we) begin
                if (m_lock[idx]) e_err = 1'b1;
                else if (field == 0) m_base[idx] = wdata;
                else if (field == 1) m_len[idx] = wdata;
                else begin
                    m_attr[idx] = wdata[2:0];
                    if (wdata[7]) m_lock[idx] = 1'b1;
                end
            end else begin
                if (field == 0)      e_rd = m_base[idx];
                else if (field == 1) e_rd = m_len[idx];
                else                 e_rd = {56'b0, m_lock[idx], 4'b0, m_attr[idx]};
            end
        end

        @(posedge clk);
        #1;
        if (r) for (int p = 0; p < NP; p++) prev[p] = '{v: 1'b0, hit: 1'b0, idx: 3'b0, attr: 3'b0};

        check("cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'(e_rv));
        check("cfg_err",    64'(bus.cfg_err_o),    64'(e_err));
        check("cfg_rdata",  bus.cfg_rdata_o,       e_rd);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("lkp_valid[%0d]", p), 64'(bus.lkp_valid_o[p]), 64'(prev[p].v));
            check($sformatf("lkp_hit[%0d]", p),   64'(bus.lkp_hit_o[p]),   64'(prev[p].hit));
            check($sformatf("lkp_idx[%0d]", p),   64'(bus.lkp_idx_o[p*3 +: 3]),  64'(prev[p].idx));
            check($sformatf("lkp_attr[%0d]", p),  64'(bus.lkp_attr_o[p*3 +: 3]), 64'(prev[p].attr));
            prev[p] = cur[p];
        end
    endtask

    task automatic wr(input int idx, input int field, input logic [63:0] d);
        cycle(1'b0, 1'b1, 1'b1, idx, field, d, 2'b00, 64'h0, 64'h0);
    endtask

    task automatic rd(input int idx, input int field);
        cycle(1'b0, 1'b1, 1'b0, idx, field, 64'h0, 2'b00, 64'h0, 64'h0);
    endtask

    task automatic lk(input logic [1:0] lv, input logic [63:0] a0, input logic [63:0] a1);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 64'h0, lv, a0, a1);
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return {$urandom, $urandom};
        if (sel == 1) return 64'h8000_0000 + 64'($urandom_range(0, 32'h4000_0100)) - 64'h80;
        return 64'($urandom_range(0, 32'h0001_2000));
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_idx_i = '0;
        bus.cfg_field_i = '0; bus.cfg_wdata_i = '0;
        bus.lkp_valid_i = '0; bus.lkp_addr_i = '0;
        for (int p = 0; p < NP; p++) prev[p] = '{v: 1'b0, hit: 1'b0, idx: 3'b0, attr: 3'b0};
        model_reset();

        cycle(1'b1, 1'b0, 1'b0, 0, 0, 64'h0, 2'b00, 64'h0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 64'h0, 2'b00, 64'h0, 64'h0);

        // Reset-loaded entry 0: hit inside, miss just past the end.
        lk(2'b11, 64'h8000_0000, 64'hC000_0000);
        lk(2'b11, 64'hBFFF_FFFF, 64'h8000_0000);
        lk(2'b00, 64'h0, 64'h0);

        // Overlapping regions: lower index wins.
        wr(1, 0, 64'h1_0000);
        wr(1, 1, 64'h1_0000);
        wr(1, 2, 64'h04);
        wr(3, 0, 64'h0);
        wr(3, 1, 64'h10_0000);
        wr(3, 2, 64'h02);
        lk(2'b11, 64'h1_8000, 64'h1_8000);
        lk(2'b11, 64'h0_8000, 64'h2_0000);
        lk(2'b00, 64'h0, 64'h0);

        // Lock: writes after locking are rejected, reads still allowed.
        wr(2, 0, 64'h55);
        wr(2, 2, 64'h81);
        wr(2, 0, 64'h1234);
        rd(2, 0);
        rd(2, 2);
        wr(2, 2, 64'h00);
        rd(2, 2);

        // Write/lookup race on entry 0 length.
        cycle(1'b0, 1'b1, 1'b1, 0, 1, 64'h0, 2'b01, 64'h8000_0000, 64'h0);
        lk(2'b01, 64'h8000_0000, 64'h0);
        lk(2'b00, 64'h0, 64'h0);

        // Region reaching the top of the address space does not wrap to zero.
        wr(3, 1, 64'h0);
        wr(4, 0, 64'hFFFF_FFFF_FFFF_F000);
        wr(4, 1, 64'h2000);
        wr(4, 2, 64'h06);
        lk(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        lk(2'b11, 64'hFFFF_FFFF_FFFF_EFFF, 64'hFFFF_FFFF_FFFF_F000);
        lk(2'b00, 64'h0, 64'h0);

        // Out-of-range index and reserved field.
        rd(6, 0);
        wr(7, 1, 64'h1000);
        rd(1, 3);
        wr(1, 3, 64'hFFFF);
        rd(1, 0);

        for (int n = 0; n < 400; n++) begin
            bit          rq, we, r;
            int          idx, field;
            logic [63:0] d;
            r     = ($urandom_range(0, 99) == 0);
            rq    = $urandom_range(0, 1);
            we    = $urandom_range(0, 1);
            idx   = $urandom_range(0, 7);
            field = $urandom_range(0, 3);
            case (field)
                0:       d = 64'($urandom_range(0, 16)) << 12;
                1:       d = 64'($urandom_range(0, 8)) << 12;
                2:       d = {56'b0, ($urandom_range(0, 15) == 0), 7'($urandom)};
                default: d = {$urandom, $urandom};
            endcase
            cycle(r, rq, we, idx, field, d, 2'($urandom), rand_addr(), rand_addr());
        end

        // Reset with lookups in flight on both ports.
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 64'h0, 2'b00, 64'h0, 64'h0);
        lk(2'b11, 64'h8000_0000, 64'h8000_0010);
        lk(2'b11, 64'h8000_0020, 64'h8000_0030);
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 64'h0, 2'b11, 64'h8000_0000, 64'h8000_0000);
        lk(2'b00, 64'h0, 64'h0);
        lk(2'b00, 64'h0, 64'h0);
        lk(2'b11, 64'h8000_0000, 64'h0);
        lk(2'b00, 64'h0, 64'h0);
        lk(2'b00, 64'h0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
